fifo_uart_tx_drain: RTL and testbench
=====================================

Name: fifo_uart_tx_drain

Overview:
- Downstream consumer of the 8-deep byte FIFO.
- Pops one byte at a time via fifo_read whenever the FIFO is non-empty and transmission is enabled.
- Serialises each byte onto a UART-style line: start bit, DATA_WIDTH data bits LSB first, optional even-parity bit, one stop bit.
- Never reads an empty FIFO, so the FIFO's read-on-empty warning must never fire while this block is the sole reader.

Parameters:
- DATA_WIDTH, 8, width of fifo_data_out and of the serialised payload.
- CLKS_PER_BIT, 4, clk cycles per line bit; legal range is 1 or more.
- PARITY_EN, 0. When 1, an even-parity bit is inserted between the last data bit and the stop bit.
- CNT_WIDTH, 16, width of the bytes_sent counter.

Ports:
- clk  input  1  sole clock; all state changes on posedge clk.
- rst_  input  1  synchronous reset, active-high; sampled on posedge clk.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data_out  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_read is high.
- fifo_read  output  1  pop strobe to the FIFO.
- tx_en  input  1  permits fetching a new byte.
- txd  output  1  serial line; idles high.
- busy  output  1  high whenever state is not IDLE.
- byte_done  output  1  one-cycle pulse on completion of a stop bit.
- bytes_sent  output  CNT_WIDTH  count of completed frames.

Behaviour:
- Reset (rst_=1 at posedge):
  - Next cycle: state=IDLE, txd=1, fifo_read=0, busy=0, byte_done=0, bytes_sent=0.
  - Bit/cycle counters and the shift register are cleared.
  - Reset mid-frame aborts immediately; a byte already popped is discarded.
- States: IDLE, REQ, CAPT, START, DATA, PARITY, STOP.
- IDLE:
  - txd=1.
  - If tx_en=1 and fifo_empty=0 at the edge, go to REQ; otherwise stay.
- REQ:
  - fifo_read=1 for exactly this one cycle (decoded from state; high in no other state).
  - Always go to CAPT.
- CAPT:
  - shift register <= fifo_data_out at the end of this cycle.
  - Parity is computed as the XOR of the captured byte.
  - Go to START.
- START: txd=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - txd = shift_reg[0] for CLKS_PER_BIT cycles per bit; shift right after each bit.
  - After DATA_WIDTH bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: txd = even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles, then STOP.
- STOP:
  - txd=1 for CLKS_PER_BIT cycles.
  - On the last cycle: byte_done=1 and bytes_sent increments. bytes_sent wraps from all-ones to 0.
  - Next state is REQ if tx_en=1 and fifo_empty=0, else IDLE.
- txd is registered and changes only at state/bit boundaries; it stays high in IDLE, REQ and CAPT.
- Latency: from the edge where IDLE samples tx_en=1 and fifo_empty=0, fifo_read is high in cycle +1 and txd falls at cycle +3.
- Frame length (START through STOP):
  - (DATA_WIDTH+2)*CLKS_PER_BIT cycles with no parity.
  - Add CLKS_PER_BIT when PARITY_EN=1.
- Back-to-back frames: minimum 2 extra high cycles (REQ, CAPT) between stop bit and next start bit.
- tx_en low mid-frame: the current frame completes unchanged; no further REQ.
- fifo_empty is sampled only in IDLE and on the last STOP cycle; it is ignored otherwise.
- busy = (state != IDLE).

Test Plan:
- Reset: after rst_=1 for 2 cycles → txd=1, fifo_read=0, busy=0, bytes_sent=0; the assertion holds on every reset cycle.
- Single byte 0xA5, CLKS_PER_BIT=4, PARITY_EN=0 → fifo_read high for exactly 1 cycle. txd then runs 0,1,0,1,0,0,1,0,1,1, each bit held for 4 cycles (40 cycles total). byte_done pulses once; bytes_sent=1.
- Empty FIFO with tx_en=1 for 100 cycles → fifo_read never asserted, txd constant 1, busy=0.
- Three bytes queued (0x01, 0x80, 0xFF), tx_en=1 → three frames in order, with exactly 2 high cycles between each stop and the next start. FIFO ends empty; bytes_sent=3.
- PARITY_EN=1, byte 0x07 → parity bit 1 and frame length 44 cycles; byte 0x03 → parity bit 0.
- Boundary cases:
  - tx_en dropped during DATA of frame 1 with 2 bytes queued → frame 1 completes and the second byte stays in the FIFO.
  - rst_ pulsed during DATA → txd=1 the next cycle and state=IDLE.
  - bytes_sent preloaded near wrap via 0xFFFF frames → next frame wraps it to 0.

Source files
------------

// File: rtl/fifo_uart_tx_drain.sv
// Drains an 8-deep byte FIFO and serialises each byte onto a UART-style line:
// start bit, LSB-first data, optional even parity, one stop bit.
module fifo_uart_tx_drain #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_read,
  input  logic                  tx_en,
  output logic                  txd,
  output logic                  busy,
  output logic                  byte_done,
  output logic [CNT_WIDTH-1:0]  bytes_sent
);

  localparam int unsigned CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_CAPT, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                r_state;
  logic [CLK_W-1:0]      r_clk_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_parity;
  logic                  r_txd;
  logic                  r_fifo_read;
  logic                  r_busy;
  logic                  r_byte_done;
  logic [CNT_WIDTH-1:0]  r_bytes_sent;

  logic                  w_bit_end;
  logic                  w_last_bit;
  logic                  w_fetch;
  logic [DATA_WIDTH-1:0] w_shift_next;

  assign w_bit_end    = (r_clk_cnt == CLK_W'(CLKS_PER_BIT - 1));
  assign w_last_bit   = (r_bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign w_fetch      = tx_en & ~fifo_empty;
  assign w_shift_next = r_shift >> 1;

  // Frame sequencer; every output is updated together with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state      <= S_IDLE;
      r_clk_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_txd        <= 1'b1;
      r_fifo_read  <= 1'b0;
      r_busy       <= 1'b0;
      r_byte_done  <= 1'b0;
      r_bytes_sent <= '0;
    end else begin
      r_fifo_read <= 1'b0;
      r_byte_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (w_fetch) begin
            r_state     <= S_REQ;
            r_fifo_read <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_REQ: begin
          r_state <= S_CAPT;
        end
        S_CAPT: begin
          r_shift   <= fifo_data_out;
          r_parity  <= ^fifo_data_out;
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          r_txd     <= 1'b0;
          r_state   <= S_START;
        end
        S_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_txd     <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CLK_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_shift   <= w_shift_next;
            if (w_last_bit) begin
              r_bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                r_txd   <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_txd   <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
              r_txd     <= w_shift_next[0];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CLK_W'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_txd     <= 1'b1;
            r_state   <= S_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + CLK_W'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt    <= '0;
            r_byte_done  <= 1'b1;
            r_bytes_sent <= r_bytes_sent + CNT_WIDTH'(1);
            // Back-to-back frames go straight to the next pop.
            if (w_fetch) begin
              r_state     <= S_REQ;
              r_fifo_read <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CLK_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_read  = r_fifo_read;
  assign txd        = r_txd;
  assign busy       = r_busy;
  assign byte_done  = r_byte_done;
  assign bytes_sent = r_bytes_sent;

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Directed bench: one no-parity instance (16-bit counter) and one parity instance
// (4-bit counter, so the wrap is reachable), each fed by a small FIFO model.
module tb_fifo_uart_tx_drain;

  logic clk = 1'b0;
  logic rst_;
  logic tx_en_a, tx_en_b;

  logic       rd_a, txd_a, busy_a, bd_a;
  logic [15:0] sent_a;
  logic [7:0] dout_a;
  logic       empty_a;

  logic       rd_b, txd_b, busy_b, bd_b;
  logic [3:0] sent_b;
  logic [7:0] dout_b;
  logic       empty_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_a [0:31];
  logic [7:0] mem_b [0:31];
  int push_a = 0, pop_a = 0, push_b = 0, pop_b = 0;
  int rd_a_cnt = 0, bd_a_cnt = 0, rd_b_cnt = 0, bd_b_cnt = 0, rd_empty_viol = 0;

  always #5 clk = ~clk;

  fifo_uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_(rst_), .fifo_empty(empty_a), .fifo_data_out(dout_a),
    .fifo_read(rd_a), .tx_en(tx_en_a), .txd(txd_a), .busy(busy_a),
    .byte_done(bd_a), .bytes_sent(sent_a)
  );

  fifo_uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst_(rst_), .fifo_empty(empty_b), .fifo_data_out(dout_b),
    .fifo_read(rd_b), .tx_en(tx_en_b), .txd(txd_b), .busy(busy_b),
    .byte_done(bd_b), .bytes_sent(sent_b)
  );

  // FIFO models: data appears the cycle after the pop strobe.
  assign empty_a = (push_a == pop_a);
  assign empty_b = (push_b == pop_b);

  always @(posedge clk) begin
    if (rd_a) begin
      dout_a <= mem_a[pop_a[4:0]];
      pop_a  <= pop_a + 1;
    end
    if (rd_b) begin
      dout_b <= mem_b[pop_b[4:0]];
      pop_b  <= pop_b + 1;
    end
    if (rd_a) rd_a_cnt <= rd_a_cnt + 1;
    if (rd_b) rd_b_cnt <= rd_b_cnt + 1;
    if (bd_a) bd_a_cnt <= bd_a_cnt + 1;
    if (bd_b) bd_b_cnt <= bd_b_cnt + 1;
    if ((rd_a && empty_a) || (rd_b && empty_b)) rd_empty_viol <= rd_empty_viol + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte_a(input logic [7:0] v);
    mem_a[push_a[4:0]] = v;
    push_a++;
  endtask

  task automatic push_byte_b(input logic [7:0] v);
    mem_b[push_b[4:0]] = v;
    push_b++;
  endtask

  // Expected line level at cycle idx counted from the REQ cycle (idx 0).
  function automatic logic exp_txd(input logic [7:0] b, input int idx, input bit par);
    int f;
    if (idx < 2) return 1'b1;
    f = (idx - 2) / 4;
    if (f == 0) return 1'b0;
    if (f <= 8) return b[f-1];
    if (par && f == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic stream_a(input string tag, input logic [7:0] b);
    for (int idx = 0; idx < 42; idx++) begin
      tick();
      if (idx == 0) check({tag, "_rd_req"}, 32'(rd_a), 32'd1);
      if (idx == 1) check({tag, "_rd_capt"}, 32'(rd_a), 32'd0);
      check($sformatf("%s_txd[%0d]", tag, idx), 32'(txd_a), 32'(exp_txd(b, idx, 1'b0)));
    end
  endtask

  task automatic stream_b(input string tag, input logic [7:0] b);
    for (int idx = 0; idx < 46; idx++) begin
      tick();
      if (idx == 0) check({tag, "_rd_req"}, 32'(rd_b), 32'd1);
      check($sformatf("%s_txd[%0d]", tag, idx), 32'(txd_b), 32'(exp_txd(b, idx, 1'b1)));
    end
    check({tag, "_busy_last_stop"}, 32'(busy_b), 32'd1);
  endtask

  initial begin
    rst_    = 1'b1;
    tx_en_a = 1'b0;
    tx_en_b = 1'b0;

    // Reset held two cycles
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_txd", 32'(txd_a), 32'd1);
      check("rst_rd", 32'(rd_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_sent", 32'(sent_a), 32'd0);
      check("rst_bd", 32'(bd_a), 32'd0);
    end
    rst_ = 1'b0;
    tick();

    // Single byte 0xA5, no parity
    push_byte_a(8'hA5);
    tx_en_a = 1'b1;
    stream_a("a5", 8'hA5);
    tick();
    check("a5_byte_done", 32'(bd_a), 32'd1);
    check("a5_sent", 32'(sent_a), 32'd1);
    check("a5_busy_after", 32'(busy_a), 32'd0);
    tick();
    check("a5_bd_count", 32'(bd_a_cnt), 32'd1);
    check("a5_rd_count", 32'(rd_a_cnt), 32'd1);

    // Empty FIFO with tx_en high: nothing happens
    for (int i = 0; i < 100; i++) begin
      tick();
      check("empty_idle", 32'({rd_a, txd_a, busy_a}), 32'b010);
    end

    // Three back-to-back bytes after a fresh reset
    rst_ = 1'b1;
    tick();
    check("rst2_sent", 32'(sent_a), 32'd0);
    rst_ = 1'b0;
    push_byte_a(8'h01);
    push_byte_a(8'h80);
    push_byte_a(8'hFF);
    stream_a("b01", 8'h01);
    stream_a("b80", 8'h80);
    stream_a("bff", 8'hFF);
    tick();
    check("three_sent", 32'(sent_a), 32'd3);
    check("three_empty", 32'(empty_a), 32'd1);
    check("three_busy", 32'(busy_a), 32'd0);
    check("three_rd_count", 32'(rd_a_cnt), 32'd4);

    // tx_en dropped during DATA: second byte must stay queued
    push_byte_a(8'h3C);
    push_byte_a(8'h55);
    for (int i = 0; i < 14; i++) tick();
    check("drop_in_data", 32'(busy_a), 32'd1);
    tx_en_a = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    check("drop_busy", 32'(busy_a), 32'd0);
    check("drop_not_empty", 32'(empty_a), 32'd0);
    check("drop_sent", 32'(sent_a), 32'd4);
    check("drop_rd_count", 32'(rd_a_cnt), 32'd5);
    tx_en_a = 1'b1;
    stream_a("b55", 8'h55);
    tick();
    check("resume_sent", 32'(sent_a), 32'd5);
    check("resume_empty", 32'(empty_a), 32'd1);

    // Reset pulsed mid-frame
    push_byte_a(8'h0F);
    for (int i = 0; i < 14; i++) tick();
    check("midrst_txd_before", 32'(txd_a), 32'd1);
    check("midrst_busy_before", 32'(busy_a), 32'd1);
    rst_ = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("midrst_txd", 32'(txd_a), 32'd1);
      check("midrst_busy", 32'(busy_a), 32'd0);
      check("midrst_rd", 32'(rd_a), 32'd0);
      check("midrst_sent", 32'(sent_a), 32'd0);
    end
    rst_ = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("midrst_idle", 32'({rd_a, txd_a, busy_a}), 32'b010);
    check("midrst_empty", 32'(empty_a), 32'd1);

    // Parity instance: 0x07 -> parity 1, 0x03 -> parity 0, 44-cycle frames
    tx_en_b = 1'b1;
    push_byte_b(8'h07);
    stream_b("p07", 8'h07);
    tick();
    check("p07_busy_after", 32'(busy_b), 32'd0);
    check("p07_sent", 32'(sent_b), 32'd1);
    push_byte_b(8'h03);
    stream_b("p03", 8'h03);
    tick();
    check("p03_sent", 32'(sent_b), 32'd2);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 13; i++) push_byte_b(8'(i * 17 + 3));
    begin
      int n;
      n = 0;
      tick();
      while ((busy_b || !empty_b) && n < 1000) begin
        tick();
        n++;
      end
      check("wrap_timeout", 32'(n < 1000), 32'd1);
    end
    check("wrap_pre", 32'(sent_b), 32'd15);
    push_byte_b(8'hC3);
    stream_b("pc3", 8'hC3);
    tick();
    check("wrap_zero", 32'(sent_b), 32'd0);
    tick();

    check("total_rd_a", 32'(rd_a_cnt), 32'd7);
    check("total_bd_a", 32'(bd_a_cnt), 32'd6);
    check("total_rd_b", 32'(rd_b_cnt), 32'd16);
    check("total_bd_b", 32'(bd_b_cnt), 32'd16);
    check("rd_on_empty", 32'(rd_empty_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
